param_fifo: RTL and testbench

//  Parametrised synchronous show-ahead FIFO, replacing the fixed 4x8 byte FIFO in the CPU-to-peripheral paths (UART TX/RX, SPI).

---
 rtl/param_fifo_pkg.sv | 20 ++
 rtl/param_fifo_if.sv | 31 +++
 rtl/param_fifo_edge_det.sv | 30 +++
 rtl/param_fifo.sv | 145 ++++++++++++++
 tb/tb_param_fifo.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/param_fifo_pkg.sv
// Shared types for the parametrised FIFO: level update encoding and its decode helper.
package param_fifo_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic lvl_op_e lvl_op(input logic wr_ok, input logic rd_ok);
        lvl_op_e op;
        case ({wr_ok, rd_ok})
            2'b10:   op = LVL_INC;
            2'b01:   op = LVL_DEC;
            default: op = LVL_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/status bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface param_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             flush;
    logic             clr_flags;
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [AW:0]      level;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, clr_flags, data_in, push, pop,
        input  data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  flush, clr_flags, data_in, push, pop,
        output data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/param_fifo_edge_det.sv
// Strobe qualifier: passes the raw strobe (level mode) or only its rising edge (edge mode).
module fifo_edge_det #(
    parameter int EDGE_MODE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_in,
    output logic pulse_out
);
    localparam logic EDGE_EN = (EDGE_MODE != 0);

    logic prev_d;
    logic prev_q;

    // Strobe history always follows the raw strobe.
    always_comb begin
        prev_d = strobe_in;
    end

    // History resets high so a strobe held through reset does not fire on release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse_out = strobe_in & (~prev_q | ~EDGE_EN);
endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock show-ahead FIFO with fill level, thresholds, flush and sticky
// overflow/underflow flags; push/pop optionally act on strobe rising edges.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int EDGE_MODE = 1,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 2
) (
    input logic         clk,
    input logic         reset_n,
    param_fifo_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_L    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L    = (AW + 1)'(AE_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("param_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("param_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_d, wr_ptr_q;
    logic [AW:0] rd_ptr_d, rd_ptr_q;
    logic [AW:0] level_d, level_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;

    logic push_s, pop_s;
    logic empty_s, full_s;
    logic wr_ok_s, rd_ok_s, mem_we_s;
    logic ovf_set_s, udf_set_s;

    fifo_edge_det #(.EDGE_MODE(EDGE_MODE)) u_push_det (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (bus.push),
        .pulse_out (push_s)
    );

    fifo_edge_det #(.EDGE_MODE(EDGE_MODE)) u_pop_det (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (bus.pop),
        .pulse_out (pop_s)
    );

    // Wrap bit distinguishes full from empty when the low pointer bits match.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Next-state for pointers, level and sticky flags; flush overrides all strobes.
    always_comb begin
        wr_ok_s   = push_s & (~full_s | pop_s);
        rd_ok_s   = pop_s & ~empty_s;
        mem_we_s  = 1'b0;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            mem_we_s  = wr_ok_s;
            ovf_set_s = push_s & full_s & ~pop_s;
            udf_set_s = pop_s & empty_s;
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (lvl_op(wr_ok_s, rd_ok_s))
                LVL_INC: level_d = level_q + PTR_ONE;
                LVL_DEC: level_d = level_q - PTR_ONE;
                default: level_d = level_q;
            endcase
        end
        // A new event outranks a clear request in the same cycle.
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (bus.clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (udf_set_s) begin
            underflow_d = 1'b1;
        end else if (bus.clr_flags) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we_s) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.data_out     = mem[rd_ptr_q[AW-1:0]];
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.almost_empty = (level_q <= AE_L);
    assign bus.almost_full  = (level_q >= AF_L);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: an edge-mode and a level-mode instance share one stimulus stream and
// are compared every cycle against a queue-based reference of the FIFO rules.
module tb_param_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic flush, clr_flags, push, pop;
    logic [WIDTH-1:0] data_in;

    int checks = 0;
    int errors = 0;

    param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
    param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

    assign if0.flush = flush;  assign if1.flush = flush;
    assign if0.clr_flags = clr_flags;  assign if1.clr_flags = clr_flags;
    assign if0.data_in = data_in;  assign if1.data_in = data_in;
    assign if0.push = push;  assign if1.push = push;
    assign if0.pop = pop;  assign if1.pop = pop;

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE_MODE(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut_edge (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );
    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE_MODE(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut_level (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );

    always #5 clk = ~clk;

    // Reference state per instance: 0 = edge mode, 1 = level mode.
    logic [WIDTH-1:0] mq [2][$];
    logic m_ovf [2];
    logic m_udf [2];
    logic m_pp  [2];
    logic m_pq  [2];

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            logic pu, po, ovf_set, udf_set;
            int n;
            if (!reset_n) begin
                mq[m].delete();
                m_ovf[m] = 1'b0;
                m_udf[m] = 1'b0;
                m_pp[m]  = 1'b1;
                m_pq[m]  = 1'b1;
            end else begin
                pu = (m == 0) ? (push & ~m_pp[m]) : push;
                po = (m == 0) ? (pop & ~m_pq[m]) : pop;
                n  = mq[m].size();
                ovf_set = 1'b0;
                udf_set = 1'b0;
                if (flush) begin
                    mq[m].delete();
                end else begin
                    ovf_set = pu && (n == DEPTH) && !po;
                    udf_set = po && (n == 0);
                    if (po && n > 0) void'(mq[m].pop_front());
                    if (pu && (n < DEPTH || po)) mq[m].push_back(data_in);
                end
                m_ovf[m] = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : m_ovf[m]);
                m_udf[m] = udf_set ? 1'b1 : (clr_flags ? 1'b0 : m_udf[m]);
                m_pp[m]  = push;
                m_pq[m]  = pop;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            int n;
            logic [4:0] lv;
            logic e, f, ae, af, ov, ud;
            logic [WIDTH-1:0] dout;
            n    = mq[m].size();
            lv   = (m == 0) ? if0.level : if1.level;
            e    = (m == 0) ? if0.empty : if1.empty;
            f    = (m == 0) ? if0.full : if1.full;
            ae   = (m == 0) ? if0.almost_empty : if1.almost_empty;
            af   = (m == 0) ? if0.almost_full : if1.almost_full;
            ov   = (m == 0) ? if0.overflow : if1.overflow;
            ud   = (m == 0) ? if0.underflow : if1.underflow;
            dout = (m == 0) ? if0.data_out : if1.data_out;
            chk($sformatf("%s[%0d].level", tag, m), 32'(lv), 32'(n));
            chk($sformatf("%s[%0d].empty", tag, m), 32'(e), 32'(n == 0));
            chk($sformatf("%s[%0d].full", tag, m), 32'(f), 32'(n == DEPTH));
            chk($sformatf("%s[%0d].almost_empty", tag, m), 32'(ae), 32'(n <= AE));
            chk($sformatf("%s[%0d].almost_full", tag, m), 32'(af), 32'(n >= AF));
            chk($sformatf("%s[%0d].overflow", tag, m), 32'(ov), 32'(m_ovf[m]));
            chk($sformatf("%s[%0d].underflow", tag, m), 32'(ud), 32'(m_udf[m]));
            if (n > 0) chk($sformatf("%s[%0d].data_out", tag, m), 32'(dout), 32'(mq[m][0]));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    // One-cycle strobe pulse followed by an idle cycle, so both modes see exactly one event.
    task automatic pulse(input string tag, input logic do_push, input logic do_pop, input logic [WIDTH-1:0] d);
        data_in = d;
        push    = do_push;
        pop     = do_pop;
        step(tag);
        push = 1'b0;
        pop  = 1'b0;
        step(tag);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; clr_flags = 1'b0; push = 1'b1; pop = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 3; i++) step("reset");
        chk("reset_level", 32'(if0.level), 32'd0);
        chk("reset_empty", 32'(if0.empty), 32'd1);

        // Push held across reset release: edge instance must not write.
        reset_n = 1'b1;
        step("held_push");
        step("held_push");
        chk("held_push_no_write", 32'(if0.level), 32'd0);
        push = 1'b0;
        step("idle");
        reset_n = 1'b0; step("reset2");
        reset_n = 1'b1; step("idle2");

        for (int i = 1; i <= DEPTH; i++) begin
            pulse("fill", 1'b1, 1'b0, 8'(i));
            if (i == AF - 1) chk("af_before_12", 32'(if0.almost_full), 32'd0);
            if (i == AF) chk("af_at_12", 32'(if0.almost_full), 32'd1);
        end
        chk("full_after_16", 32'(if0.full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_order", 32'(if0.data_out), 32'(i));
            pulse("drain", 1'b0, 1'b1, 8'h00);
        end
        chk("empty_after_drain", 32'(if0.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) pulse("refill", 1'b1, 1'b0, 8'(8'hC0 + i));
        pulse("ovf_push", 1'b1, 1'b0, 8'hAA);
        chk("ovf_set", 32'(if0.overflow), 32'd1);
        chk("ovf_level", 32'(if0.level), 32'd16);
        clr_flags = 1'b1; step("clr"); clr_flags = 1'b0; step("clr_idle");
        chk("ovf_cleared", 32'(if0.overflow), 32'd0);

        pulse("full_push_pop", 1'b1, 1'b1, 8'h55);
        chk("fpp_level", 32'(if0.level), 32'd16);
        chk("fpp_no_ovf", 32'(if0.overflow), 32'd0);
        chk("fpp_head", 32'(if0.data_out), 32'hC1);

        flush = 1'b1; step("flush_a"); flush = 1'b0; step("flush_a_idle");
        pulse("empty_push_pop", 1'b1, 1'b1, 8'h33);
        chk("epp_level", 32'(if0.level), 32'd1);
        chk("epp_data", 32'(if0.data_out), 32'h33);
        chk("epp_udf", 32'(if0.underflow), 32'd1);

        for (int i = 0; i < 4; i++) pulse("lvl5", 1'b1, 1'b0, 8'(8'h70 + i));
        chk("lvl5", 32'(if0.level), 32'd5);
        flush = 1'b1; push = 1'b1; data_in = 8'hEE;
        step("flush_push");
        flush = 1'b0;
        chk("flush_level", 32'(if0.level), 32'd0);
        chk("flush_keeps_udf", 32'(if0.underflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h90 + i);
            step("held3");
        end
        chk("level_mode_held3", 32'(if1.level), 32'd3);
        chk("edge_mode_held3", 32'(if0.level), 32'd0);
        push = 1'b0;
        step("held3_idle");

        for (int i = 0; i < 600; i++) begin
            reset_n   = ($urandom_range(0, 149) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            clr_flags = ($urandom_range(0, 19) == 0);
            push      = ($urandom_range(0, 99) < 55);
            pop       = ($urandom_range(0, 99) < 45);
            data_in   = 8'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
